// File: rtl/relu_frame_buffer.sv
// relu_frame_buffer: streams pixels through optional ReLU and packs them
// row-major into a registered frame handed to the pooling stage.
module relu_frame_buffer #(
   parameter int IP_DATA_WIDTH = 8,
   parameter int ARRAY_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   relu_en,
   input  logic                   s_valid,
   input  logic [IP_DATA_WIDTH:0] s_data,
   input  logic                   s_last,
   output logic                   s_ready,
   output logic [IP_DATA_WIDTH:0] input_vec [0:ARRAY_WIDTH*ARRAY_WIDTH-1],
   output logic                   frame_valid,
   input  logic                   frame_ready,
   output logic                   frame_err
);

   localparam int N  = ARRAY_WIDTH * ARRAY_WIDTH;
   localparam int AW = $clog2(N);
   localparam int CW = AW + 1;

   typedef enum logic {
      FILL,
      FULL
   } state_t;

   state_t                 state, state_n;
   logic [CW-1:0]          cnt, cnt_n;
   logic                   err_n;
   logic                   acc;
   logic [IP_DATA_WIDTH:0] pix;

   assign s_ready     = !rst && (state == FILL || frame_ready);
   assign acc         = s_valid && s_ready;
   assign frame_valid = (state == FULL);
   assign pix         = (relu_en && s_data[IP_DATA_WIDTH]) ? '0 : s_data;

   // cnt is 0 in FULL, so a bypass accept is handled like a FILL accept
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      err_n   = 1'b0;
      unique case (state)
         FILL: ;
         FULL: if (frame_ready) state_n = FILL;
      endcase
      if (acc) begin
         if (cnt == CW'(N - 1)) begin
            state_n = FULL;
            cnt_n   = '0;
            err_n   = !s_last;
         end else if (s_last) begin
            cnt_n = '0;
            err_n = 1'b1;
         end else begin
            cnt_n = cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         cnt       <= '0;
         frame_err <= 1'b0;
         for (int i = 0; i < N; i++) input_vec[i] <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         frame_err <= err_n;
         if (acc) input_vec[cnt[AW-1:0]] <= pix;
      end
   end

endmodule
